// File: rtl/adder_tb_pkg.sv
// Shared types, mode encodings and LFSR helpers for the adder stimulus generator.
package adder_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRESENT,
    ST_DONE
  } gen_state_e;

  localparam logic [1:0]  MODE_RAND   = 2'd0;
  localparam logic [1:0]  MODE_CORNER = 2'd1;
  localparam logic [1:0]  MODE_WALK   = 2'd2;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam int          NUM_CORNER  = 4;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ LFSR_TAPS;
    return r;
  endfunction

endpackage

// File: rtl/adder_vector_gen_lfsr32.sv
// 32-bit Galois LFSR with seed load and step enable.
module lfsr32
  import adder_tb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] seed_fix;
  logic [31:0] state_d;
  logic [31:0] state_q;

  // A zero seed would lock the register at zero, so it is promoted to one.
  always_comb begin
    seed_fix = (seed == 32'd0) ? 32'd1 : seed;
  end

  // Reload on load, advance on step, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed_fix;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // Reset restarts the sequence from the seed.
  always_ff @(posedge clk) begin
    if (rst) state_q <= seed_fix;
    else     state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/adder_vector_gen.sv
// Operand vector generator for the adder family: random, corner and walking-one
// vectors presented over a valid/ready handshake.
module adder_vector_gen
  import adder_tb_pkg::*;
#(
  parameter int          N           = 128,
  parameter int          NUM_VECTORS = 30000,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  localparam int         CW          = $clog2(NUM_VECTORS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          ready,
  output logic          valid,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  output logic          cin,
  output logic [CW-1:0] vec_idx,
  output logic          busy,
  output logic          done
);

  localparam int NW  = N / 32;
  localparam int WCW = $clog2(2 * NW + 1);
  localparam int PW  = $clog2(N);
  localparam int SW  = $clog2(NUM_CORNER);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECTORS - 1);
  localparam logic [PW-1:0] LAST_POS = PW'(N - 1);
  localparam logic [N-1:0]  ONES     = {N{1'b1}};
  localparam logic [N-1:0]  ALT_A    = {(N/2){2'b01}};
  localparam logic [N-1:0]  ALT_B    = {(N/2){2'b10}};
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  gen_state_e    state_d, state_q;
  logic [1:0]    mode_d, mode_q;
  logic [N-1:0]  a_d, a_q;
  logic [N-1:0]  b_d, b_q;
  logic          cin_d, cin_q;
  logic [CW-1:0] vec_idx_d, vec_idx_q;
  logic [PW-1:0] pos_d, pos_q;
  logic [WCW-1:0] word_d, word_q;
  logic          valid_d, valid_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;

  logic          lfsr_load;
  logic          lfsr_step_en;
  logic [31:0]   lfsr_q;
  logic [31:0]   lfsr_nxt;
  logic          is_rand;

  lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step_en),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Post-step LFSR value used for the word being filled, and the random-mode decode.
  always_comb begin
    lfsr_nxt = lfsr_next(lfsr_q);
    is_rand  = (mode_q != MODE_CORNER) && (mode_q != MODE_WALK);
  end

  // Next-state logic: run control, operand filling and handshake bookkeeping.
  // pos tracks vec_idx mod N so corner and walking patterns need no divider.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    vec_idx_d    = vec_idx_q;
    pos_d        = pos_q;
    word_d       = word_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d    = mode;
          vec_idx_d = '0;
          pos_d     = '0;
          word_d    = '0;
          lfsr_load = 1'b1;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        if (is_rand) begin
          lfsr_step_en = 1'b1;
          word_d       = word_q + 1'b1;
          if (int'(word_q) < NW) begin
            a_d[32*int'(word_q) +: 32] = lfsr_nxt;
          end else if (int'(word_q) < 2 * NW) begin
            b_d[32*(int'(word_q) - NW) +: 32] = lfsr_nxt;
          end else begin
            cin_d   = lfsr_nxt[0];
            state_d = ST_PRESENT;
          end
        end else if (mode_q == MODE_CORNER) begin
          case (pos_q[SW-1:0])
            2'd0:    begin a_d = ONES;  b_d = '0;    cin_d = 1'b1; end
            2'd1:    begin a_d = ONES;  b_d = ONES;  cin_d = 1'b1; end
            2'd2:    begin a_d = '0;    b_d = '0;    cin_d = 1'b0; end
            default: begin a_d = ALT_A; b_d = ALT_B; cin_d = 1'b1; end
          endcase
          state_d = ST_PRESENT;
        end else begin
          a_d     = ONE << pos_q;
          b_d     = ONE << pos_q;
          cin_d   = 1'b0;
          state_d = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        if (ready) begin
          if (vec_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            vec_idx_d = vec_idx_q + 1'b1;
            pos_d     = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
            word_d    = '0;
            state_d   = ST_FILL;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_PRESENT);
    busy_d  = (state_d == ST_FILL) || (state_d == ST_PRESENT);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any run and clears the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_RAND;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      vec_idx_q <= '0;
      pos_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      vec_idx_q <= vec_idx_d;
      pos_q     <= pos_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign valid   = valid_q;
  assign a       = a_q;
  assign b       = b_q;
  assign cin     = cin_q;
  assign vec_idx = vec_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_adder_vector_gen.sv
// Bench for adder_vector_gen: three instances (random N=64, corner N=128,
// walking-one N=32) checked against a reference model of the vector rules.
module tb_adder_vector_gen;

  localparam int RN = 64;  localparam int RNV = 6;  localparam int RCW = $clog2(RNV + 1);
  localparam int CN = 128; localparam int CNV = 5;  localparam int CCW = $clog2(CNV + 1);
  localparam int WN = 32;  localparam int WNV = 34; localparam int WCW = $clog2(WNV + 1);

  logic clk = 1'b0;
  logic rst;

  logic r_start, r_ready, r_valid, r_cin, r_busy, r_done;
  logic [1:0] r_mode;
  logic [RN-1:0] r_a, r_b;
  logic [RCW-1:0] r_idx;

  logic c_start, c_ready, c_valid, c_cin, c_busy, c_done;
  logic [1:0] c_mode;
  logic [CN-1:0] c_a, c_b;
  logic [CCW-1:0] c_idx;

  logic w_start, w_ready, w_valid, w_cin, w_busy, w_done;
  logic [1:0] w_mode;
  logic [WN-1:0] w_a, w_b;
  logic [WCW-1:0] w_idx;

  int total = 0;
  int bad = 0;

  // Reference model state for random mode
  logic [31:0]   m_lfsr;
  logic [RN-1:0] cur_a, cur_b;
  logic          cur_cin;

  always #5 clk = ~clk;

  adder_vector_gen #(.N(RN), .NUM_VECTORS(RNV), .SEED(32'h0000_0001)) u_rand (
    .clk(clk), .rst(rst), .start(r_start), .mode(r_mode), .ready(r_ready),
    .valid(r_valid), .a(r_a), .b(r_b), .cin(r_cin), .vec_idx(r_idx),
    .busy(r_busy), .done(r_done));

  adder_vector_gen #(.N(CN), .NUM_VECTORS(CNV), .SEED(32'h0000_0000)) u_corner (
    .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .ready(c_ready),
    .valid(c_valid), .a(c_a), .b(c_b), .cin(c_cin), .vec_idx(c_idx),
    .busy(c_busy), .done(c_done));

  adder_vector_gen #(.N(WN), .NUM_VECTORS(WNV), .SEED(32'h0000_0001)) u_walk (
    .clk(clk), .rst(rst), .start(w_start), .mode(w_mode), .ready(w_ready),
    .valid(w_valid), .a(w_a), .b(w_b), .cin(w_cin), .vec_idx(w_idx),
    .busy(w_busy), .done(w_done));

  // Galois LFSR step written straight from the shift/xor rule
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Produce the next random vector: a words, then b words, then cin
  task automatic next_rand();
    for (int i = 0; i < RN / 32; i++) begin
      m_lfsr = ref_step(m_lfsr);
      cur_a[32*i +: 32] = m_lfsr;
    end
    for (int i = 0; i < RN / 32; i++) begin
      m_lfsr = ref_step(m_lfsr);
      cur_b[32*i +: 32] = m_lfsr;
    end
    m_lfsr  = ref_step(m_lfsr);
    cur_cin = m_lfsr[0];
  endtask

  // Corner pattern table indexed by vector number mod 4
  task automatic corner_exp(input int k, output logic [CN-1:0] ea, output logic [CN-1:0] eb,
                            output logic ec);
    ea = '0; eb = '0; ec = 1'b0;
    case (k % 4)
      0: begin ea = '1; eb = '0; ec = 1'b1; end
      1: begin ea = '1; eb = '1; ec = 1'b1; end
      2: begin ea = '0; eb = '0; ec = 1'b0; end
      default: begin
        for (int i = 0; i < CN; i++) ea[i] = (i % 2 == 0);
        eb = ~ea;
        ec = 1'b1;
      end
    endcase
  endtask

  // Pulse start on the random instance and report cycles until valid
  task automatic r_launch(output int cyc);
    @(negedge clk); r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    cyc = 1;
    while (r_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r_start = 0; r_ready = 0; r_mode = 0;
    c_start = 0; c_ready = 0; c_mode = 0;
    w_start = 0; w_ready = 0; w_mode = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({r_valid, r_busy, r_done, r_cin} !== 4'b0 || r_a !== '0 || r_b !== '0 || r_idx !== '0) begin
      bad++; $display("[TB] FAIL reset_rand got v=%b bu=%b d=%b a=%h idx=%0d want all zero",
                      r_valid, r_busy, r_done, r_a, r_idx);
    end
    total++;
    if ({c_valid, c_busy, c_done, c_cin} !== 4'b0 || c_a !== '0 || c_b !== '0 || c_idx !== '0) begin
      bad++; $display("[TB] FAIL reset_corner got v=%b bu=%b d=%b idx=%0d want all zero",
                      c_valid, c_busy, c_done, c_idx);
    end
    total++;
    if ({w_valid, w_busy, w_done, w_cin} !== 4'b0 || w_a !== '0 || w_b !== '0 || w_idx !== '0) begin
      bad++; $display("[TB] FAIL reset_walk got v=%b bu=%b d=%b idx=%0d want all zero",
                      w_valid, w_busy, w_done, w_idx);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (r_valid !== 1'b0 || r_busy !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_no_start got v=%b bu=%b want 0 0", r_valid, r_busy);
    end
  endtask

  task automatic test_random_first();
    int cyc;
    r_mode = 2'd0; r_ready = 1'b0;
    m_lfsr = 32'h1;
    r_launch(cyc);
    r_mode = 2'd1;
    total++;
    if (cyc != 6) begin
      bad++; $display("[TB] FAIL rand_latency got %0d cycles want 6", cyc);
    end
    next_rand();
    total++;
    if (r_a !== cur_a || r_b !== cur_b || r_cin !== cur_cin) begin
      bad++; $display("[TB] FAIL rand_vec0_model got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                      r_a, r_b, r_cin, cur_a, cur_b, cur_cin);
    end
    total++;
    if (r_a !== 64'hC0300002_80200003 || r_b !== 64'hB02C0003_60180001 || r_cin !== 1'b0) begin
      bad++; $display("[TB] FAIL rand_vec0_known got a=%h b=%h cin=%b want a=c030000280200003 b=b02c000360180001 cin=0",
                      r_a, r_b, r_cin);
    end
    total++;
    if (r_idx !== RCW'(0) || r_busy !== 1'b1 || r_done !== 1'b0) begin
      bad++; $display("[TB] FAIL rand_vec0_status got idx=%0d busy=%b done=%b want 0 1 0", r_idx, r_busy, r_done);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (r_valid !== 1'b1 || r_a !== cur_a || r_b !== cur_b || r_cin !== cur_cin || r_idx !== RCW'(0)) begin
        bad++; $display("[TB] FAIL stall_stable cycle %0d got v=%b a=%h idx=%0d want v=1 a=%h idx=0",
                        i, r_valid, r_a, r_idx, cur_a);
      end
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    total++;
    if (r_valid !== 1'b0 || r_idx !== RCW'(1) || r_busy !== 1'b1) begin
      bad++; $display("[TB] FAIL single_handshake got v=%b idx=%0d busy=%b want 0 1 1", r_valid, r_idx, r_busy);
    end
    cyc = 0;
    while (r_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk); cyc++;
    end
    next_rand();
    total++;
    if (cyc >= 60 || r_a !== cur_a || r_b !== cur_b || r_cin !== cur_cin || r_idx !== RCW'(1)) begin
      bad++; $display("[TB] FAIL rand_vec1 got a=%h b=%h cin=%b idx=%0d want a=%h b=%h cin=%b idx=1",
                      r_a, r_b, r_cin, r_idx, cur_a, cur_b, cur_cin);
    end
  endtask

  task automatic test_start_ignored();
    r_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (r_valid !== 1'b1 || r_idx !== RCW'(1) || r_a !== cur_a || r_b !== cur_b) begin
        bad++; $display("[TB] FAIL start_in_present cycle %0d got v=%b idx=%0d a=%h want v=1 idx=1 a=%h",
                        i, r_valid, r_idx, r_a, cur_a);
      end
    end
    r_start = 1'b0;
  endtask

  task automatic test_random_run();
    int exp_idx;
    int cyc;
    exp_idx = 1;
    for (cyc = 0; cyc < 600 && exp_idx < RNV; cyc++) begin
      r_ready = 1'($urandom_range(0, 1));
      total++;
      if ((r_busy & r_done) !== 1'b0) begin
        bad++; $display("[TB] FAIL busy_done_excl got busy=%b done=%b want not both", r_busy, r_done);
      end
      if (r_valid === 1'b1) begin
        total++;
        if (r_idx !== RCW'(exp_idx) || r_a !== cur_a || r_b !== cur_b || r_cin !== cur_cin) begin
          bad++; $display("[TB] FAIL rand_vec got idx=%0d a=%h b=%h cin=%b want idx=%0d a=%h b=%h cin=%b",
                          r_idx, r_a, r_b, r_cin, exp_idx, cur_a, cur_b, cur_cin);
        end
        if (r_ready) begin
          exp_idx++;
          if (exp_idx < RNV) next_rand();
        end
      end
      @(negedge clk);
    end
    r_ready = 1'b0;
    total++;
    if (exp_idx < RNV) begin
      bad++; $display("[TB] FAIL rand_run_timeout got %0d handshakes want %0d", exp_idx, RNV);
    end
    total++;
    if (r_done !== 1'b1 || r_valid !== 1'b0 || r_busy !== 1'b0 || r_idx !== RCW'(RNV - 1)) begin
      bad++; $display("[TB] FAIL rand_done got done=%b v=%b busy=%b idx=%0d want 1 0 0 %0d",
                      r_done, r_valid, r_busy, r_idx, RNV - 1);
    end
  endtask

  task automatic test_done_restart();
    int cyc;
    repeat (3) @(negedge clk);
    total++;
    if (r_done !== 1'b1 || r_valid !== 1'b0 || r_idx !== RCW'(RNV - 1)) begin
      bad++; $display("[TB] FAIL done_hold got done=%b v=%b idx=%0d want 1 0 %0d", r_done, r_valid, r_idx, RNV - 1);
    end
    m_lfsr = 32'h1;
    r_mode = 2'd3;
    @(negedge clk); r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    total++;
    if (r_done !== 1'b0 || r_busy !== 1'b1 || r_idx !== RCW'(0)) begin
      bad++; $display("[TB] FAIL restart_status got done=%b busy=%b idx=%0d want 0 1 0", r_done, r_busy, r_idx);
    end
    cyc = 1;
    while (r_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk); cyc++;
    end
    next_rand();
    total++;
    if (cyc != 6 || r_a !== cur_a || r_b !== cur_b || r_cin !== cur_cin || r_idx !== RCW'(0)) begin
      bad++; $display("[TB] FAIL restart_vec0 got lat=%0d a=%h b=%h idx=%0d want lat=6 a=%h b=%h idx=0",
                      cyc, r_a, r_b, r_idx, cur_a, cur_b);
    end
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    int late_valid;
    r_ready = 1'b1;
    cyc = 0;
    while (!(r_idx === RCW'(3) && r_valid === 1'b0 && r_busy === 1'b1) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    r_ready = 1'b0;
    total++;
    if (cyc >= 200) begin
      bad++; $display("[TB] FAIL reach_fill_vec3 got timeout idx=%0d want fill of vector 3", r_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({r_valid, r_busy, r_done, r_cin} !== 4'b0 || r_a !== '0 || r_b !== '0 || r_idx !== '0) begin
      bad++; $display("[TB] FAIL mid_reset got v=%b bu=%b d=%b a=%h b=%h idx=%0d want all zero",
                      r_valid, r_busy, r_done, r_a, r_b, r_idx);
    end
    late_valid = 0;
    r_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (r_valid !== 1'b0 || r_busy !== 1'b0) late_valid++;
    end
    r_ready = 1'b0;
    total++;
    if (late_valid != 0) begin
      bad++; $display("[TB] FAIL post_reset_quiet got %0d active cycles want 0", late_valid);
    end
    r_mode = 2'd0;
    r_launch(cyc);
    total++;
    if (cyc != 6 || r_a !== 64'hC0300002_80200003 || r_b !== 64'hB02C0003_60180001 || r_cin !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_replay got lat=%0d a=%h b=%h cin=%b want lat=6 a=c030000280200003 b=b02c000360180001 cin=0",
                      cyc, r_a, r_b, r_cin);
    end
  endtask

  task automatic test_corner();
    int cyc;
    int exp_idx;
    logic [CN-1:0] ea, eb;
    logic ec;
    c_mode = 2'd1; c_ready = 1'b0;
    @(negedge clk); c_start = 1'b1;
    @(negedge clk); c_start = 1'b0; c_mode = 2'd0;
    cyc = 1;
    while (c_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    total++;
    if (cyc != 2) begin
      bad++; $display("[TB] FAIL corner_latency got %0d want 2", cyc);
    end
    exp_idx = 0;
    for (cyc = 0; cyc < 300 && exp_idx < CNV; cyc++) begin
      c_ready = 1'($urandom_range(0, 1));
      if (c_valid === 1'b1) begin
        corner_exp(exp_idx, ea, eb, ec);
        total++;
        if (c_idx !== CCW'(exp_idx) || c_a !== ea || c_b !== eb || c_cin !== ec) begin
          bad++; $display("[TB] FAIL corner_vec got idx=%0d a=%h b=%h cin=%b want idx=%0d a=%h b=%h cin=%b",
                          c_idx, c_a, c_b, c_cin, exp_idx, ea, eb, ec);
        end
        if (c_ready) exp_idx++;
      end
      @(negedge clk);
    end
    c_ready = 1'b0;
    total++;
    if (exp_idx < CNV || c_done !== 1'b1 || c_valid !== 1'b0 || c_busy !== 1'b0) begin
      bad++; $display("[TB] FAIL corner_done got hs=%0d done=%b v=%b busy=%b want hs=%0d 1 0 0",
                      exp_idx, c_done, c_valid, c_busy, CNV);
    end
  endtask

  task automatic test_walk();
    int cyc;
    int exp_idx;
    int last_hs;
    logic [WN-1:0] ew;
    w_mode = 2'd2; w_ready = 1'b1;
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0; w_mode = 2'd0;
    exp_idx = 0;
    last_hs = 0;
    for (cyc = 0; cyc < 400 && exp_idx < WNV; cyc++) begin
      if (w_valid === 1'b1) begin
        ew = 32'h1 << (exp_idx % WN);
        total++;
        if (w_idx !== WCW'(exp_idx) || w_a !== ew || w_b !== ew || w_cin !== 1'b0) begin
          bad++; $display("[TB] FAIL walk_vec got idx=%0d a=%h b=%h cin=%b want idx=%0d a=b=%h cin=0",
                          w_idx, w_a, w_b, w_cin, exp_idx, ew);
        end
        if (exp_idx == 33) begin
          total++;
          if (w_a !== 32'h0000_0002 || w_b !== 32'h0000_0002) begin
            bad++; $display("[TB] FAIL walk_vec33 got a=%h b=%h want 00000002", w_a, w_b);
          end
        end
        if (exp_idx > 0) begin
          total++;
          if (cyc - last_hs != 2) begin
            bad++; $display("[TB] FAIL walk_throughput got %0d cycles want 2", cyc - last_hs);
          end
        end
        last_hs = cyc;
        exp_idx++;
      end
      @(negedge clk);
    end
    w_ready = 1'b0;
    total++;
    if (exp_idx < WNV || w_done !== 1'b1 || w_valid !== 1'b0 || w_idx !== WCW'(WNV - 1)) begin
      bad++; $display("[TB] FAIL walk_done got hs=%0d done=%b v=%b idx=%0d want hs=%0d 1 0 %0d",
                      exp_idx, w_done, w_valid, w_idx, WNV, WNV - 1);
    end
  endtask

  // Hard stop in case a sequence stalls outside its own bounded loops
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_random_first();
    test_backpressure();
    test_start_ignored();
    test_random_run();
    test_done_restart();
    test_reset_mid_fill();
    test_corner();
    test_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_vector_gen.md
# adder_vector_gen

Synthesizable stimulus source for the adder family (cra, csa, cla, a1csa, a1csah). It generates operand vectors (`a`, `b`, `cin`) and presents them to the adder under test over a valid/ready handshake, replacing file-driven stimulus so that benches and on-chip self-test see the same sequence. Three modes are supported: pseudo-random (32-bit LFSR), carry-chain corner patterns, and walking-one. The block sits upstream of the DUV and the reference adder. A downstream checker consumes each vector when it asserts `ready`.

## Interface
- `N`, 128, operand width; must be a multiple of 32, minimum 32.
- `NUM_VECTORS`, 30000, vectors per run; must be at least 1.
- `SEED`, 32'h0000_0001, LFSR seed; a value of 0 is replaced by 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begins a run; sampled only in IDLE or DONE.
- `mode`  in  2  0 = random, 1 = corner, 2 = walking-one, 3 = random; latched on accepted `start`.
- `ready`  in  1  consumer accepts the presented vector.
- `valid`  out  1  vector on `a`/`b`/`cin` is valid.
- `a`, `b`  out  N  operands.
- `cin`  out  1  carry-in.
- `vec_idx`  out  CW = $clog2(NUM_VECTORS+1)  index of the presented vector, 0-based.
- `busy`  out  1  high in FILL and PRESENT.
- `done`  out  1  high in DONE.

## Operation
- FSM states: IDLE, FILL, PRESENT, DONE.
- IDLE, on `start`:
  - latch `mode`;
  - `vec_idx` <= 0;
  - LFSR <= SEED;
  - go to FILL.
- DONE, on `start`: same actions as IDLE. Otherwise DONE holds and `done` stays 1.
- `start` is ignored in FILL and PRESENT.
- FILL, random mode (W = 2N/32 + 1 cycles):
  - The LFSR steps once per cycle; the post-step value is used.
  - Steps 1..N/32 fill `a` from the least-significant word upward.
  - Steps N/32+1..2N/32 fill `b` the same way.
  - The final step sets `cin` = bit 0 of the LFSR.
- FILL, corner mode (1 cycle). Pattern `vec_idx` mod 4:
  - 0: a = all ones, b = 0, cin = 1.
  - 1: a = b = all ones, cin = 1.
  - 2: a = b = 0, cin = 0.
  - 3: a = 0101…01, b = 1010…10, cin = 1.
- FILL, walking-one mode (1 cycle): k = `vec_idx` mod N; a = b = 1<<k; cin = 0.
- FILL -> PRESENT after the last fill cycle.
- PRESENT:
  - `valid` = 1; `a`, `b`, `cin` and `vec_idx` are held stable until `ready`.
  - On `valid && ready`: if `vec_idx` == NUM_VECTORS-1, go to DONE (`vec_idx` is held); otherwise increment `vec_idx` and go to FILL.
- LFSR: Galois, right-shift, taps 32'h8020_0003.
  - Step: `lsb` = s[0]; s = s>>1; if `lsb`, s ^= taps.
  - The LFSR does not advance outside FILL.
- `ready` is a don't-care outside PRESENT.

## Timing
- Reset values: state = IDLE; `valid` = `busy` = `done` = 0; `a` = `b` = 0; `cin` = 0; `vec_idx` = 0; LFSR = SEED (0 → 1).
- `rst` has priority over everything. Reset mid-run aborts with no further `valid`.
- Latency, with `start` sampled at edge t:
  - FILL occupies cycles t+1..t+W.
  - `valid` = 1 from cycle t+W+1.
  - For N=128 random, `valid` starts at t+10; corner and walking-one start at t+2.
- Throughput with `ready` held high: one vector per W+1 cycles (random), or per 2 cycles (other modes).
- After the final handshake, `done` = 1 on the next cycle and `valid` = 0.
- `busy` and `done` are never high together.

## Structure
- Package `adder_tb_pkg`:
  - state enum;
  - mode encodings (MODE_RAND, MODE_CORNER, MODE_WALK);
  - LFSR_TAPS = 32'h8020_0003;
  - corner-pattern count (4).
- Sub-module `lfsr32`: 32-bit Galois LFSR with ports `load`, `seed`, `step`, `q`.
- The top level holds the FSM, word counter, operand registers and `vec_idx`.

## Test plan
- Random, N=64, SEED=1, `ready` = 1, `start` pulse. Required response:
  - a = 64'hC0300002_80200003;
  - b = 64'hB02C0003_60180001;
  - cin = 0;
  - `vec_idx` = 0;
  - `valid` first high 6 cycles after `start`.
- Corner, N=128, NUM_VECTORS=5. Required response:
  - vector 0: a = all ones, b = 0, cin = 1;
  - vector 4 repeats pattern 0;
  - `done` = 1 after the 5th handshake.
- Walking-one, N=32, NUM_VECTORS=34: vector 33 has a = b = 32'h0000_0002, cin = 0.
- Backpressure: `ready` = 0 for 7 cycles in PRESENT. Outputs and `vec_idx` must stay stable, the LFSR must not advance, and exactly one handshake must be counted when `ready` rises.
- Reset mid-FILL at random vector 3: all outputs return to reset values. The next `start` reproduces vector 0 from the test above, bit-exact.
- `start` asserted during PRESENT is ignored. `start` in DONE restarts with `vec_idx` = 0 and the seed sequence repeats.
